// File: rtl/display_mode_scheduler_if.sv
// rtl/display_mode_scheduler_if.sv - frame-sync scheduler <-> pattern datapath bundle
// Purpose: groups the per-frame sampling inputs and the geometry outputs of
//          display_mode_scheduler into one interface.
// Signals:
//   on_off      [7:0]  mode buttons (level), only [4:0] meaningful
//   rx_data     [7:0]  sound level, unsigned
//   frame_start        one-cycle pulse at the first pixel of each frame
//   mode        [2:0]  0 = blank, 1..5 = pattern
//   active             a pattern is on screen
//   half_w     [11:0]  box half-width
//   half_h     [11:0]  box half-height
//   update             outputs refreshed this cycle
// Modports: master drives the inputs (timing/sensor side), slave is the scheduler.
interface display_mode_scheduler_if;
    logic [7:0]  on_off;
    logic [7:0]  rx_data;
    logic        frame_start;
    logic [2:0]  mode;
    logic        active;
    logic [11:0] half_w;
    logic [11:0] half_h;
    logic        update;

    modport master (
        output on_off, rx_data, frame_start,
        input  mode, active, half_w, half_h, update
    );

    modport slave (
        input  on_off, rx_data, frame_start,
        output mode, active, half_w, half_h, update
    );
endinterface

// File: rtl/display_mode_scheduler.sv
// rtl/display_mode_scheduler.sv - frame-synchronous grow/hold/shrink pattern scheduler
// Purpose: samples buttons and sound level on each frame_start and advances an
//          IDLE/GROW/HOLD/SHRINK animation; geometry changes only once per frame.
// Ports:
//   i_clk   system clock
//   i_rst   synchronous reset, active-high
//   s_if    display_mode_scheduler_if.slave (on_off, rx_data, frame_start in;
//           mode, active, half_w, half_h, update out)
// Optional feature: define AUTO_CYCLE_EN to auto-cycle modes 1..5 every
//          AUTO_FRAMES frames while loud with no button pressed.
module display_mode_scheduler #(
    parameter int H_DISP      = 1280,
    parameter int V_DISP      = 1024,
    parameter int THRESH      = 30,
    parameter int STEP        = 4,
    parameter int AUTO_FRAMES = 120
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    display_mode_scheduler_if.slave  s_if
);
    localparam logic [11:0] CAP_W    = 12'(H_DISP / 2);
    localparam logic [11:0] CAP_H    = 12'(V_DISP / 2);
    localparam logic [11:0] STEP_V   = 12'(STEP);
    localparam logic [7:0]  THRESH_V = 8'(THRESH);

    if (STEP < 1 || STEP > V_DISP / 2 || AUTO_FRAMES < 1) begin : g_bad_param
        $error("display_mode_scheduler: STEP or AUTO_FRAMES out of range");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_GROW, ST_HOLD, ST_SHRINK} state_t;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_cur, w_cur_nx;
    logic [11:0] r_half_w, r_half_h, w_half_w_nx, w_half_h_nx;
    logic        r_update;

    logic [2:0]  w_req_btn, w_req;
    logic        w_loud, w_go;
    logic [12:0] w_sum_w, w_sum_h;
    logic [11:0] w_grow_w, w_grow_h, w_shrink_w, w_shrink_h;
    logic        w_grow_full, w_shrink_done;
    logic [2:0]  w_unused_on_off;

    assign w_unused_on_off = s_if.on_off[7:5];
    assign w_loud          = (s_if.rx_data > THRESH_V);

    // Lowest set button wins.
    always_comb begin
        w_req_btn = 3'd0;
        if      (s_if.on_off[0]) w_req_btn = 3'd1;
        else if (s_if.on_off[1]) w_req_btn = 3'd2;
        else if (s_if.on_off[2]) w_req_btn = 3'd3;
        else if (s_if.on_off[3]) w_req_btn = 3'd4;
        else if (s_if.on_off[4]) w_req_btn = 3'd5;
    end

`ifdef AUTO_CYCLE_EN
    localparam int CNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

    logic [2:0]       r_auto_mode, w_auto_next;
    logic [CNT_W-1:0] r_frame_cnt, w_frame_cnt_nx;
    logic             w_use_auto, w_run, w_adv;

    assign w_use_auto  = w_loud && (w_req_btn == 3'd0);
    assign w_run       = (r_state == ST_GROW) || (r_state == ST_HOLD);
    assign w_adv       = w_use_auto && w_run && (r_frame_cnt == CNT_LAST);
    assign w_auto_next = (r_auto_mode == 3'd5) ? 3'd1 : r_auto_mode + 3'd1;
    // An advance presents the new auto mode as req, so the FSM sees a mode change.
    assign w_req       = w_use_auto ? (w_adv ? w_auto_next : r_auto_mode) : w_req_btn;

    // Counting continues only while auto mode is steering an unchanged pattern;
    // a restart (cur changes), button press, SHRINK or IDLE all clear it.
    always_comb begin
        w_frame_cnt_nx = r_frame_cnt;
        if (s_if.frame_start) begin
            if (w_use_auto && w_run && !w_adv && (w_cur_nx == r_cur))
                w_frame_cnt_nx = r_frame_cnt + 1'b1;
            else
                w_frame_cnt_nx = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_auto_mode <= 3'd1;
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= w_frame_cnt_nx;
            if (s_if.frame_start && w_adv)
                r_auto_mode <= w_auto_next;
        end
    end
`else
    assign w_req = w_req_btn;
`endif

    assign w_go = w_loud && (w_req != 3'd0);

    // Saturating steps; 13-bit sum so the cap test cannot be fooled by a wrap.
    assign w_sum_w       = {1'b0, r_half_w} + {1'b0, STEP_V};
    assign w_sum_h       = {1'b0, r_half_h} + {1'b0, STEP_V};
    assign w_grow_w      = (w_sum_w >= {1'b0, CAP_W}) ? CAP_W : w_sum_w[11:0];
    assign w_grow_h      = (w_sum_h >= {1'b0, CAP_H}) ? CAP_H : w_sum_h[11:0];
    assign w_shrink_w    = (r_half_w > STEP_V) ? (r_half_w - STEP_V) : 12'd0;
    assign w_shrink_h    = (r_half_h > STEP_V) ? (r_half_h - STEP_V) : 12'd0;
    assign w_grow_full   = (w_grow_w == CAP_W) && (w_grow_h == CAP_H);
    assign w_shrink_done = (w_shrink_w == 12'd0) && (w_shrink_h == 12'd0);

    always_comb begin
        w_state_nx  = r_state;
        w_cur_nx    = r_cur;
        w_half_w_nx = r_half_w;
        w_half_h_nx = r_half_h;
        if (s_if.frame_start) begin
            if (r_state == ST_IDLE) begin
                if (w_go) begin
                    w_state_nx  = ST_GROW;
                    w_cur_nx    = w_req;
                    w_half_w_nx = STEP_V;
                    w_half_h_nx = STEP_V;
                end
            end else if (!w_go) begin
                // Shrink step; reaching 0/0 blanks in this same update.
                w_half_w_nx = w_shrink_w;
                w_half_h_nx = w_shrink_h;
                w_state_nx  = w_shrink_done ? ST_IDLE : ST_SHRINK;
                if (w_shrink_done)
                    w_cur_nx = 3'd0;
            end else if (w_req != r_cur) begin
                w_state_nx  = ST_GROW;
                w_cur_nx    = w_req;
                w_half_w_nx = STEP_V;
                w_half_h_nx = STEP_V;
            end else if (r_state != ST_HOLD) begin
                // GROW continues, SHRINK resumes growing from its current size.
                w_half_w_nx = w_grow_w;
                w_half_h_nx = w_grow_h;
                w_state_nx  = w_grow_full ? ST_HOLD : ST_GROW;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cur    <= 3'd0;
            r_half_w <= 12'd0;
            r_half_h <= 12'd0;
            r_update <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cur    <= w_cur_nx;
            r_half_w <= w_half_w_nx;
            r_half_h <= w_half_h_nx;
            r_update <= s_if.frame_start;
        end
    end

    assign s_if.active = (r_state != ST_IDLE);
    assign s_if.mode   = (r_state != ST_IDLE) ? r_cur : 3'd0;
    assign s_if.half_w = r_half_w;
    assign s_if.half_h = r_half_h;
    assign s_if.update = r_update;
endmodule
